// File: rtl/cache_tag_controller.sv
// Set-associative tag/valid/dirty store with a lookup -> evict -> allocate FSM driving an external LRU tracker.
// Optional macro CACHE_TAG_DIRTY_TRACK_EN enables dirty tracking and the dirty-victim eviction handshake.
module cache_tag_controller #(
    parameter int NUM_SETS = 4,
    parameter int ASSOC    = 4,
    parameter int TAG_SIZE = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [$clog2(NUM_SETS)-1:0] req_set,
    input  logic [TAG_SIZE-1:0]         req_tag,
    input  logic                        req_write,
    output logic                        resp_valid,
    output logic                        resp_hit,
    output logic [$clog2(ASSOC)-1:0]    resp_way,
    output logic [$clog2(NUM_SETS)-1:0] lru_set,
    output logic [$clog2(ASSOC)-1:0]    lru_selected_way,
    output logic                        lru_process,
    input  logic [$clog2(ASSOC)-1:0]    lru_victim_way,
    output logic                        evict_valid,
    input  logic                        evict_ready,
    output logic [TAG_SIZE-1:0]         evict_tag,
    output logic [$clog2(ASSOC)-1:0]    evict_way
);
    localparam int SET_W = $clog2(NUM_SETS);
    localparam int WAY_W = $clog2(ASSOC);

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_EVICT, S_ALLOC} state_t;

    state_t              r_state;
    logic [SET_W-1:0]    r_req_set;
    logic [TAG_SIZE-1:0] r_req_tag;
    logic                r_hit;
    logic [WAY_W-1:0]    r_way;
    logic                r_resp_valid;
    logic                r_resp_hit;
    logic [WAY_W-1:0]    r_resp_way;
    logic                r_lru_process;
    logic [WAY_W-1:0]    r_lru_sel;

    logic [TAG_SIZE-1:0] r_tag_mem [NUM_SETS][ASSOC];
    logic [ASSOC-1:0]    r_valid   [NUM_SETS];

    logic [ASSOC-1:0]    w_match;
    logic [ASSOC-1:0]    w_invalid;
    logic                w_hit;
    logic [WAY_W-1:0]    w_hit_way;
    logic                w_has_invalid;
    logic [WAY_W-1:0]    w_first_invalid;
    logic [WAY_W-1:0]    w_repl_way;

`ifdef CACHE_TAG_DIRTY_TRACK_EN
    logic                r_write;
    logic [ASSOC-1:0]    r_dirty [NUM_SETS];
    logic                r_evict_valid;
    logic [TAG_SIZE-1:0] r_evict_tag;
    logic [WAY_W-1:0]    r_evict_way;
    logic                w_repl_dirty;
`else
    logic                w_unused;
    assign w_unused = ^{req_write, evict_ready};
`endif

    // Hit detection uses the incoming request so the hit response is registered at acceptance.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_match   = '0;
        w_invalid = '0;
        for (int w = 0; w < ASSOC; w++) begin
            w_match[w]   = r_valid[req_set][w] && (r_tag_mem[req_set][w] == req_tag);
            w_invalid[w] = !r_valid[r_req_set][w];
        end
    end

    always_comb begin
        w_hit           = 1'b0;
        w_hit_way       = '0;
        w_has_invalid   = 1'b0;
        w_first_invalid = '0;
        for (int w = ASSOC - 1; w >= 0; w--) begin
            if (w_match[w]) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
            if (w_invalid[w]) begin
                w_has_invalid   = 1'b1;
                w_first_invalid = WAY_W'(w);
            end
        end
    end

    assign w_repl_way = w_has_invalid ? w_first_invalid : lru_victim_way;

`ifdef CACHE_TAG_DIRTY_TRACK_EN
    assign w_repl_dirty = r_valid[r_req_set][w_repl_way] && r_dirty[r_req_set][w_repl_way];
`endif

    // NOTE: tag storage has no reset; valid bits alone decide whether a tag is meaningful.
    always_ff @(posedge clk) begin
        if (r_state == S_ALLOC) begin
            r_tag_mem[r_req_set][r_way] <= r_req_tag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_req_set     <= '0;
            r_req_tag     <= '0;
            r_hit         <= 1'b0;
            r_way         <= '0;
            r_resp_valid  <= 1'b0;
            r_resp_hit    <= 1'b0;
            r_resp_way    <= '0;
            r_lru_process <= 1'b0;
            r_lru_sel     <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                r_valid[s] <= '0;
            end
`ifdef CACHE_TAG_DIRTY_TRACK_EN
            r_write       <= 1'b0;
            r_evict_valid <= 1'b0;
            r_evict_tag   <= '0;
            r_evict_way   <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                r_dirty[s] <= '0;
            end
`endif
        end else begin
            r_resp_valid  <= 1'b0;
            r_resp_hit    <= 1'b0;
            r_resp_way    <= '0;
            r_lru_process <= 1'b0;
            r_lru_sel     <= '0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_req_set <= req_set;
                        r_req_tag <= req_tag;
                        r_hit     <= w_hit;
                        r_way     <= w_hit_way;
`ifdef CACHE_TAG_DIRTY_TRACK_EN
                        r_write   <= req_write;
`endif
                        if (w_hit) begin
                            r_resp_valid  <= 1'b1;
                            r_resp_hit    <= 1'b1;
                            r_resp_way    <= w_hit_way;
                            r_lru_process <= 1'b1;
                            r_lru_sel     <= w_hit_way;
                        end
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (r_hit) begin
`ifdef CACHE_TAG_DIRTY_TRACK_EN
                        r_dirty[r_req_set][r_way] <= r_dirty[r_req_set][r_way] | r_write;
`endif
                        r_state <= S_IDLE;
                    end else begin
                        r_way <= w_repl_way;
`ifdef CACHE_TAG_DIRTY_TRACK_EN
                        if (w_repl_dirty) begin
                            r_evict_valid <= 1'b1;
                            r_evict_tag   <= r_tag_mem[r_req_set][w_repl_way];
                            r_evict_way   <= w_repl_way;
                            r_state       <= S_EVICT;
                        end else
`endif
                        begin
                            r_resp_valid  <= 1'b1;
                            r_resp_way    <= w_repl_way;
                            r_lru_process <= 1'b1;
                            r_lru_sel     <= w_repl_way;
                            r_state       <= S_ALLOC;
                        end
                    end
                end
                S_EVICT: begin
`ifdef CACHE_TAG_DIRTY_TRACK_EN
                    if (evict_ready) begin
                        r_evict_valid <= 1'b0;
                        r_evict_tag   <= '0;
                        r_evict_way   <= '0;
                        r_resp_valid  <= 1'b1;
                        r_resp_way    <= r_way;
                        r_lru_process <= 1'b1;
                        r_lru_sel     <= r_way;
                        r_state       <= S_ALLOC;
                    end
`else
                    r_state <= S_IDLE;
`endif
                end
                S_ALLOC: begin
                    r_valid[r_req_set][r_way] <= 1'b1;
`ifdef CACHE_TAG_DIRTY_TRACK_EN
                    r_dirty[r_req_set][r_way] <= r_write;
`endif
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Ready is gated by reset so it reads 0 while reset is held even though the state is IDLE.
    assign req_ready        = (r_state == S_IDLE) && !reset;
    assign lru_set          = (r_state == S_IDLE) ? '0 : r_req_set;
    assign resp_valid       = r_resp_valid;
    assign resp_hit         = r_resp_hit;
    assign resp_way         = r_resp_way;
    assign lru_process      = r_lru_process;
    assign lru_selected_way = r_lru_sel;

`ifdef CACHE_TAG_DIRTY_TRACK_EN
    assign evict_valid = r_evict_valid;
    assign evict_tag   = r_evict_tag;
    assign evict_way   = r_evict_way;
`else
    assign evict_valid = 1'b0;
    assign evict_tag   = '0;
    assign evict_way   = '0;
`endif

endmodule

// File: tb/tb_cache_tag_controller.sv
// Directed self-checking bench for cache_tag_controller with a behavioural true-LRU tracker attached.
// Follows CACHE_TAG_DIRTY_TRACK_EN to select the eviction or no-eviction expectations.
module tb_cache_tag_controller;
    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_set;
    logic [7:0] req_tag;
    logic       req_write;
    logic       resp_valid;
    logic       resp_hit;
    logic [1:0] resp_way;
    logic [1:0] lru_set;
    logic [1:0] lru_selected_way;
    logic       lru_process;
    logic [1:0] lru_victim_way;
    logic       evict_valid;
    logic       evict_ready;
    logic [7:0] evict_tag;
    logic [1:0] evict_way;

    int n_tests = 0;
    int n_fail  = 0;

    cache_tag_controller #(.NUM_SETS(4), .ASSOC(4), .TAG_SIZE(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_set(req_set), .req_tag(req_tag), .req_write(req_write),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
        .lru_set(lru_set), .lru_selected_way(lru_selected_way), .lru_process(lru_process),
        .lru_victim_way(lru_victim_way),
        .evict_valid(evict_valid), .evict_ready(evict_ready),
        .evict_tag(evict_tag), .evict_way(evict_way)
    );

    always #5 clk = ~clk;

    // True-LRU tracker: rank 0 is least recently used, rank 3 most recently used.
    logic [1:0] lru_rank [4][4];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < 4; s++)
                for (int w = 0; w < 4; w++)
                    lru_rank[s][w] <= 2'(w);
        end else if (lru_process) begin
            for (int w = 0; w < 4; w++)
                if (lru_rank[lru_set][w] > lru_rank[lru_set][lru_selected_way])
                    lru_rank[lru_set][w] <= lru_rank[lru_set][w] - 2'd1;
            lru_rank[lru_set][lru_selected_way] <= 2'd3;
        end
    end

    always_comb begin
        lru_victim_way = '0;
        for (int w = 0; w < 4; w++)
            if (lru_rank[lru_set][w] == 2'd0) lru_victim_way = 2'(w);
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // Called at a negedge; returns #1 after the accepting posedge.
    task automatic send(input logic [1:0] s, input logic [7:0] t, input logic w);
        req_valid = 1'b1;
        req_set   = s;
        req_tag   = t;
        req_write = w;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        check("req_ready_before_accept", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'b0;
    endtask

    task automatic expect_hit(input string name, input logic [1:0] way);
        @(negedge clk);
        check({name, "_resp_valid"}, 32'(resp_valid), 32'd1);
        check({name, "_resp_hit"}, 32'(resp_hit), 32'd1);
        check({name, "_resp_way"}, 32'(resp_way), 32'(way));
        check({name, "_lru_process"}, 32'(lru_process), 32'd1);
        check({name, "_lru_selected_way"}, 32'(lru_selected_way), 32'(way));
        @(negedge clk);
        check({name, "_resp_valid_after"}, 32'(resp_valid), 32'd0);
        check({name, "_resp_way_after"}, 32'(resp_way), 32'd0);
    endtask

    task automatic expect_miss(input string name, input logic [1:0] s, input logic [1:0] way);
        @(negedge clk);
        check({name, "_lookup_resp_valid"}, 32'(resp_valid), 32'd0);
        check({name, "_lookup_lru_set"}, 32'(lru_set), 32'(s));
        check({name, "_lookup_evict_valid"}, 32'(evict_valid), 32'd0);
        @(negedge clk);
        check({name, "_resp_valid"}, 32'(resp_valid), 32'd1);
        check({name, "_resp_hit"}, 32'(resp_hit), 32'd0);
        check({name, "_resp_way"}, 32'(resp_way), 32'(way));
        check({name, "_lru_process"}, 32'(lru_process), 32'd1);
        check({name, "_lru_selected_way"}, 32'(lru_selected_way), 32'(way));
        check({name, "_evict_valid"}, 32'(evict_valid), 32'd0);
        @(negedge clk);
        check({name, "_resp_valid_after"}, 32'(resp_valid), 32'd0);
        check({name, "_lru_process_after"}, 32'(lru_process), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_set     = '0;
        req_tag     = '0;
        req_write   = 1'b0;
        evict_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_lru_process", 32'(lru_process), 32'd0);
        check("rst_evict_valid", 32'(evict_valid), 32'd0);
        check("rst_lru_set", 32'(lru_set), 32'd0);
        reset = 1'b0;
        #1;

        // First transfer on the first edge after reset release.
        send(2'd1, 8'h3A, 1'b0);
        expect_miss("first_miss_s1", 2'd1, 2'd0);
        send(2'd1, 8'h3A, 1'b0);
        expect_hit("repeat_hit_s1", 2'd0);

        // Fill set 2, refresh ways 1-3, so way 0 becomes the LRU victim.
        send(2'd2, 8'h10, 1'b0); expect_miss("fill_s2_w0", 2'd2, 2'd0);
        send(2'd2, 8'h11, 1'b0); expect_miss("fill_s2_w1", 2'd2, 2'd1);
        send(2'd2, 8'h12, 1'b0); expect_miss("fill_s2_w2", 2'd2, 2'd2);
        send(2'd2, 8'h13, 1'b0); expect_miss("fill_s2_w3", 2'd2, 2'd3);
        send(2'd2, 8'h11, 1'b0); expect_hit("touch_s2_11", 2'd1);
        send(2'd2, 8'h12, 1'b0); expect_hit("touch_s2_12", 2'd2);
        send(2'd2, 8'h13, 1'b0); expect_hit("touch_s2_13", 2'd3);
        send(2'd2, 8'h20, 1'b0); expect_miss("lru_replace_s2", 2'd2, 2'd0);
        send(2'd2, 8'h10, 1'b0); expect_miss("evicted_tag_s2", 2'd2, 2'd1);
        send(2'd1, 8'h3A, 1'b0); expect_hit("other_set_kept", 2'd0);

        // Set 0: dirty 0x10 in way 0, fill the rest, then force way 0 out.
        send(2'd0, 8'h10, 1'b1); expect_miss("fill_s0_w0", 2'd0, 2'd0);
        send(2'd0, 8'h11, 1'b0); expect_miss("fill_s0_w1", 2'd0, 2'd1);
        send(2'd0, 8'h12, 1'b0); expect_miss("fill_s0_w2", 2'd0, 2'd2);
        send(2'd0, 8'h13, 1'b0); expect_miss("fill_s0_w3", 2'd0, 2'd3);
        send(2'd0, 8'h14, 1'b1);
`ifdef CACHE_TAG_DIRTY_TRACK_EN
        @(negedge clk);
        check("evict_lookup_evict_valid", 32'(evict_valid), 32'd0);
        check("evict_lookup_resp_valid", 32'(resp_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("evict_hold_valid", 32'(evict_valid), 32'd1);
            check("evict_hold_tag", 32'(evict_tag), 32'h10);
            check("evict_hold_way", 32'(evict_way), 32'd0);
            check("evict_hold_resp_valid", 32'(resp_valid), 32'd0);
        end
        evict_ready = 1'b1;
        @(negedge clk);
        evict_ready = 1'b0;
        check("evict_alloc_resp_valid", 32'(resp_valid), 32'd1);
        check("evict_alloc_resp_hit", 32'(resp_hit), 32'd0);
        check("evict_alloc_resp_way", 32'(resp_way), 32'd0);
        check("evict_alloc_lru_process", 32'(lru_process), 32'd1);
        check("evict_alloc_lru_way", 32'(lru_selected_way), 32'd0);
        check("evict_alloc_evict_valid", 32'(evict_valid), 32'd0);
        check("evict_alloc_evict_tag", 32'(evict_tag), 32'd0);
        @(negedge clk);
        check("evict_after_resp_valid", 32'(resp_valid), 32'd0);

        // Write-hit ways 1-3 so way 0 (dirty 0x14) is the next victim.
        send(2'd0, 8'h11, 1'b1); expect_hit("whit_s0_11", 2'd1);
        send(2'd0, 8'h12, 1'b1); expect_hit("whit_s0_12", 2'd2);
        send(2'd0, 8'h13, 1'b1); expect_hit("whit_s0_13", 2'd3);
        send(2'd0, 8'h16, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("evict2_valid", 32'(evict_valid), 32'd1);
        check("evict2_tag", 32'(evict_tag), 32'h14);
        check("evict2_way", 32'(evict_way), 32'd0);
`else
        expect_miss("no_evict_alloc", 2'd0, 2'd0);
        @(negedge clk);
`endif
        reset = 1'b1;
        #1;
        check("midrst_evict_valid", 32'(evict_valid), 32'd0);
        check("midrst_evict_tag", 32'(evict_tag), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        check("midrst_lru_set", 32'(lru_set), 32'd0);
        check("midrst_resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("postrst_req_ready", 32'(req_ready), 32'd1);
        send(2'd0, 8'h10, 1'b0); expect_miss("postrst_s0_10", 2'd0, 2'd0);
        send(2'd1, 8'h3A, 1'b0); expect_miss("postrst_s1_3a", 2'd1, 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
